// File: rtl/evt_burst_gen.sv
// Programmable event-pulse burst source: N single-cycle pulses spaced P cycles apart,
// followed by a one-cycle done pulse. All outputs are registered.
//
// state | meaning
// IDLE  | waiting for start_in; sent_out holds the last burst's count
// RUN   | burst in progress; timer counts down to the next pulse
// DONE  | done_out high for this single cycle, start_in ignored
module evt_burst_gen #(
   parameter int COUNT_WIDTH  = 16,
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    start_in,
   input  logic [PERIOD_WIDTH-1:0] period_in,
   input  logic [COUNT_WIDTH-1:0]  num_in,
   input  logic                    abort_in,
   output logic                    evt_out,
   output logic                    busy_out,
   output logic                    done_out,
   output logic [COUNT_WIDTH-1:0]  sent_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [COUNT_WIDTH-1:0]  C_ONE = 1;
   localparam logic [PERIOD_WIDTH-1:0] P_ONE = 1;

   state_t                  r_state;
   logic [PERIOD_WIDTH-1:0] r_period_m1;
   logic [PERIOD_WIDTH-1:0] r_timer;
   logic [COUNT_WIDTH-1:0]  r_remain;
   logic [COUNT_WIDTH-1:0]  r_sent;
   logic                    r_evt;
   logic                    r_busy;
   logic                    r_done;

   // A zero period is treated as one, so the reload value bottoms out at zero.
   logic [PERIOD_WIDTH-1:0] w_period_m1;
   assign w_period_m1 = (period_in == '0) ? '0 : (period_in - P_ONE);

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state     <= IDLE;
         r_period_m1 <= '0;
         r_timer     <= '0;
         r_remain    <= '0;
         r_sent      <= '0;
         r_evt       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_evt  <= 1'b0;
               r_done <= 1'b0;
               if (start_in) begin
                  if (num_in != '0) begin
                     r_period_m1 <= w_period_m1;
                     r_timer     <= w_period_m1;
                     r_remain    <= num_in - C_ONE;
                     r_sent      <= C_ONE;
                     r_evt       <= 1'b1;
                     r_busy      <= 1'b1;
                     r_state     <= RUN;
                  end else begin
                     r_sent  <= '0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            RUN: begin
               // Remaining count reaches zero only once the final pulse is out.
               if (abort_in || (r_remain == '0)) begin
                  r_evt   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (r_timer == '0) begin
                  r_evt    <= 1'b1;
                  r_sent   <= r_sent + C_ONE;
                  r_remain <= r_remain - C_ONE;
                  r_timer  <= r_period_m1;
               end else begin
                  r_evt   <= 1'b0;
                  r_timer <= r_timer - P_ONE;
               end
            end
            DONE: begin
               r_evt   <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_evt   <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign evt_out  = r_evt;
   assign busy_out = r_busy;
   assign done_out = r_done;
   assign sent_out = r_sent;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Directed bench for evt_burst_gen: pulse timing, zero period/count, abort,
// mid-burst input changes, reset mid-burst and full-width burst length.
module tb_evt_burst_gen;

   logic        clk_in;
   logic        rst_in;
   logic        start_in;
   logic [15:0] period_in;
   logic [15:0] num_in;
   logic        abort_in;
   logic        evt_out;
   logic        busy_out;
   logic        done_out;
   logic [15:0] sent_out;

   int n_chk;
   int n_pass;

   evt_burst_gen #(.COUNT_WIDTH(16), .PERIOD_WIDTH(16)) u_dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .start_in  (start_in),
      .period_in (period_in),
      .num_in    (num_in),
      .abort_in  (abort_in),
      .evt_out   (evt_out),
      .busy_out  (busy_out),
      .done_out  (done_out),
      .sent_out  (sent_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk_outs(input string tag, input int e_evt, input int e_busy,
                           input int e_done, input int e_sent);
      chk({tag, "_evt"},  {31'd0, evt_out},  e_evt);
      chk({tag, "_busy"}, {31'd0, busy_out}, e_busy);
      chk({tag, "_done"}, {31'd0, done_out}, e_done);
      chk({tag, "_sent"}, {16'd0, sent_out}, e_sent);
   endtask

   // Runs one burst and checks every cycle from A through the idle cycle after done.
   // With hold set, start_in stays high and period/num switch to np/nn in cycle A+1.
   task automatic run_burst(input string id, input int p, input int n, input bit hold,
                            input int np, input int nn);
      int pe;
      int last;
      int e_evt;
      int e_sent;
      pe   = (p == 0) ? 1 : p;
      last = (n - 1) * pe;
      period_in = 16'(p);
      num_in    = 16'(n);
      start_in  = 1'b1;
      tick();
      if (!hold) start_in = 1'b0;
      for (int k = 0; k <= last + 2; k++) begin
         e_evt  = ((k % pe) == 0 && (k / pe) < n) ? 1 : 0;
         e_sent = (k / pe + 1 < n) ? (k / pe + 1) : n;
         chk_outs($sformatf("%s_k%0d", id, k), e_evt, (k <= last) ? 1 : 0,
                  (k == last + 1) ? 1 : 0, e_sent);
         if (hold && k == 1) begin
            period_in = 16'(np);
            num_in    = 16'(nn);
         end
         if (k != last + 2) tick();
      end
   endtask

   initial begin
      int pulses;
      bit got_done;
      n_chk     = 0;
      n_pass    = 0;
      rst_in    = 1'b0;
      start_in  = 1'b0;
      abort_in  = 1'b0;
      period_in = 16'd0;
      num_in    = 16'd0;
      tick();
      tick();
      chk_outs("reset", 0, 0, 0, 0);
      rst_in = 1'b1;
      tick();
      chk_outs("idle", 0, 0, 0, 0);

      run_burst("p3n4", 3, 4, 1'b0, 0, 0);
      run_burst("p0n3", 0, 3, 1'b0, 0, 0);
      run_burst("p4n1", 4, 1, 1'b0, 0, 0);

      // zero-length burst
      num_in    = 16'd0;
      period_in = 16'd2;
      start_in  = 1'b1;
      tick();
      start_in = 1'b0;
      chk_outs("n0_a", 0, 0, 1, 0);
      tick();
      chk_outs("n0_b", 0, 0, 0, 0);
      tick();
      chk_outs("n0_c", 0, 0, 0, 0);

      // abort sampled on the edge where pulse 3 would have been issued
      period_in = 16'd5;
      num_in    = 16'd10;
      start_in  = 1'b1;
      tick();
      start_in = 1'b0;
      for (int k = 0; k <= 9; k++) begin
         chk_outs($sformatf("abort_k%0d", k), (k % 5 == 0) ? 1 : 0, 1, 0, (k < 5) ? 1 : 2);
         if (k == 9) abort_in = 1'b1;
         tick();
      end
      abort_in = 1'b0;
      chk_outs("abort_done", 0, 0, 1, 2);
      tick();
      chk_outs("abort_after", 0, 0, 0, 2);

      // start held high, inputs changed mid-burst, re-accept after done
      run_burst("hold", 2, 4, 1'b1, 7, 1);
      tick();
      chk_outs("reacc_a", 1, 1, 0, 1);
      start_in = 1'b0;
      tick();
      chk_outs("reacc_b", 0, 0, 1, 1);
      tick();
      chk_outs("reacc_c", 0, 0, 0, 1);

      // reset mid-burst
      period_in = 16'd2;
      num_in    = 16'd5;
      start_in  = 1'b1;
      tick();
      start_in = 1'b0;
      tick();
      tick();
      chk_outs("pre_rst", 1, 1, 0, 2);
      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
      chk_outs("mid_rst", 0, 0, 0, 0);
      tick();
      chk_outs("post_rst", 0, 0, 0, 0);
      run_burst("after_rst", 1, 2, 1'b0, 0, 0);

      // maximum burst length
      period_in = 16'd1;
      num_in    = 16'hFFFF;
      start_in  = 1'b1;
      tick();
      start_in = 1'b0;
      pulses   = 0;
      got_done = 1'b0;
      for (int k = 0; k < 70000; k++) begin
         if (evt_out) pulses++;
         if (done_out) begin
            got_done = 1'b1;
            break;
         end
         tick();
      end
      chk("max_done", {31'd0, got_done}, 1);
      chk("max_pulses", pulses, 65535);
      chk("max_sent", {16'd0, sent_out}, 65535);
      chk("max_busy", {31'd0, busy_out}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
